// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// fifo_wr_arbiter : round-robin, burst-limited write-port arbiter for sync_FIFO
// Rev 1.0
// ============================================================================
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            accept,
  input  logic                          fifo_full,
  output logic                          fifo_w_enable,
  output logic [DATA_WIDTH-1:0]         fifo_write_data,
  output logic                          busy,
  output logic [2:0]                    owner
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [2:0]         owner_q, owner_d;
  logic [2:0]         last_q, last_d;
  logic [3:0]         count_q, count_d;

  logic [7:0]            req_pad;
  logic [7:0]            gnt_pad;
  logic [DATA_WIDTH-1:0] slice [8];
  logic [2:0]            search_base;
  logic [2:0]            win_idx;
  logic                  win_found;
  logic                  owner_req;
  logic                  wr;
  logic                  release_now;

  // Pad producer vectors to the 3-bit owner index range so indexing is uniform.
  assign req_pad = 8'(req);
  assign gnt_pad = 8'(gnt_q);

  for (genvar i = 0; i < 8; i++) begin : g_slice
    if (i < NUM_REQ) begin : g_used
      assign slice[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end else begin : g_unused
      assign slice[i] = '0;
    end
  end

  assign owner_req   = req_pad[owner_q];
  assign wr          = (state_q == GRANT) && gnt_pad[owner_q] && owner_req && !fifo_full;
  assign release_now = (state_q == GRANT) &&
                       (!owner_req || (wr && (count_q == 4'(MAX_BURST - 1))));
  assign search_base = (state_q == GRANT) ? owner_q : last_q;

  // Search starts just after the base index and wraps, so the base itself is tried last.
  always_comb begin
    logic [3:0] cand;
    win_idx   = '0;
    win_found = 1'b0;
    cand      = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = {1'b0, search_base} + 4'(i);
      if (cand >= 4'(NUM_REQ)) begin
        cand = cand - 4'(NUM_REQ);
      end
      if (!win_found && req_pad[cand[2:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[2:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    last_d  = last_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d = GRANT;
          gnt_d   = NUM_REQ'(1) << win_idx;
          owner_d = win_idx;
          last_d  = win_idx;
          count_d = '0;
        end
      end
      GRANT: begin
        if (wr) begin
          count_d = count_q + 4'd1;
        end
        if (release_now) begin
          if (win_found) begin
            gnt_d   = NUM_REQ'(1) << win_idx;
            owner_d = win_idx;
            last_d  = win_idx;
            count_d = '0;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            owner_d = '0;
            count_d = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        owner_d = '0;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      last_q  <= 3'(NUM_REQ - 1);
      count_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      count_q <= count_d;
    end
  end

  // Write strobes are combinational from the registered grant so a stalled word never slips through.
  always_comb begin
    gnt             = gnt_q;
    owner           = owner_q;
    busy            = (state_q == GRANT);
    fifo_w_enable   = wr;
    accept          = wr ? gnt_q : '0;
    fifo_write_data = (state_q == GRANT) ? slice[owner_q] : '0;
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// tb_fifo_wr_arbiter : directed vector table plus a sync_FIFO integration sequence.
module tb_fifo_wr_arbiter;

  localparam int NUM_REQ    = 4;
  localparam int DATA_WIDTH = 8;
  localparam int MAX_BURST  = 4;

  logic                          clock = 1'b0;
  logic                          reset = 1'b0;
  logic [NUM_REQ-1:0]            req = '0;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data = '0;
  logic [NUM_REQ-1:0]            gnt;
  logic [NUM_REQ-1:0]            accept;
  logic                          fifo_full = 1'b0;
  logic                          fifo_w_enable;
  logic [DATA_WIDTH-1:0]         fifo_write_data;
  logic                          busy;
  logic [2:0]                    owner;

  int tests = 0;
  int fails = 0;

  fifo_wr_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .DATA_WIDTH(DATA_WIDTH),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .req            (req),
    .req_data       (req_data),
    .gnt            (gnt),
    .accept         (accept),
    .fifo_full      (fifo_full),
    .fifo_w_enable  (fifo_w_enable),
    .fifo_write_data(fifo_write_data),
    .busy           (busy),
    .owner          (owner)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] data;
    logic        full;
    logic [3:0]  e_gnt;
    logic        e_wen;
    logic [3:0]  e_acc;
    logic [7:0]  e_wd;
    logic        e_busy;
    logic [2:0]  e_owner;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic r, input logic [3:0] rq, input logic [31:0] d,
                              input logic f, input logic [3:0] g, input logic w,
                              input logic [3:0] a, input logic [7:0] wd, input logic b,
                              input logic [2:0] o);
    vec_t v;
    v.rst_n = r;  v.req = rq;  v.data = d;   v.full = f;
    v.e_gnt = g;  v.e_wen = w; v.e_acc = a;  v.e_wd = wd;
    v.e_busy = b; v.e_owner = o;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  logic [7:0] q[$];
  int         j[4];
  int         writes;
  int         cyc;

  initial begin
    // rst req  data          full gnt   wen acc   wd     busy own
    // single producer, data changes on each accept
    add(1, 4'b0000, 32'h0,         0, 4'b0000, 0, 4'b0000, 8'h00, 0, 0);
    add(1, 4'b0001, 32'h00000011,  0, 4'b0000, 0, 4'b0000, 8'h00, 0, 0);
    add(1, 4'b0001, 32'h00000011,  0, 4'b0001, 1, 4'b0001, 8'h11, 1, 0);
    add(1, 4'b0001, 32'h00000012,  0, 4'b0001, 1, 4'b0001, 8'h12, 1, 0);
    add(1, 4'b0001, 32'h00000013,  0, 4'b0001, 1, 4'b0001, 8'h13, 1, 0);
    add(1, 4'b0000, 32'h00000013,  0, 4'b0001, 0, 4'b0000, 8'h13, 1, 0);
    add(1, 4'b0000, 32'h0,         0, 4'b0000, 0, 4'b0000, 8'h00, 0, 0);
    // burst limit with two producers
    add(0, 4'b0000, 32'h0,         0, 4'b0000, 0, 4'b0000, 8'h00, 0, 0);
    add(1, 4'b0011, 32'h0000B0A0,  0, 4'b0000, 0, 4'b0000, 8'h00, 0, 0);
    for (int k = 0; k < 4; k++)
      add(1, 4'b0011, 32'h0000B0A0, 0, 4'b0001, 1, 4'b0001, 8'hA0, 1, 0);
    for (int k = 0; k < 4; k++)
      add(1, 4'b0011, 32'h0000B0A0, 0, 4'b0010, 1, 4'b0010, 8'hB0, 1, 1);
    add(1, 4'b0011, 32'h0000B0A0,  0, 4'b0001, 1, 4'b0001, 8'hA0, 1, 0);
    add(1, 4'b0000, 32'h0000B0A0,  0, 4'b0001, 0, 4'b0000, 8'hA0, 1, 0);
    add(1, 4'b0000, 32'h0,         0, 4'b0000, 0, 4'b0000, 8'h00, 0, 0);
    // round robin, each producer leaves after one word
    add(0, 4'b0000, 32'h0,         0, 4'b0000, 0, 4'b0000, 8'h00, 0, 0);
    add(1, 4'b1111, 32'hC3C2C1C0,  0, 4'b0000, 0, 4'b0000, 8'h00, 0, 0);
    add(1, 4'b1111, 32'hC3C2C1C0,  0, 4'b0001, 1, 4'b0001, 8'hC0, 1, 0);
    add(1, 4'b1110, 32'hC3C2C1C0,  0, 4'b0001, 0, 4'b0000, 8'hC0, 1, 0);
    add(1, 4'b1110, 32'hC3C2C1C0,  0, 4'b0010, 1, 4'b0010, 8'hC1, 1, 1);
    add(1, 4'b1100, 32'hC3C2C1C0,  0, 4'b0010, 0, 4'b0000, 8'hC1, 1, 1);
    add(1, 4'b1100, 32'hC3C2C1C0,  0, 4'b0100, 1, 4'b0100, 8'hC2, 1, 2);
    add(1, 4'b1000, 32'hC3C2C1C0,  0, 4'b0100, 0, 4'b0000, 8'hC2, 1, 2);
    add(1, 4'b1000, 32'hC3C2C1C0,  0, 4'b1000, 1, 4'b1000, 8'hC3, 1, 3);
    add(1, 4'b0001, 32'hC3C2C1C0,  0, 4'b1000, 0, 4'b0000, 8'hC3, 1, 3);
    add(1, 4'b0001, 32'hC3C2C1C0,  0, 4'b0001, 1, 4'b0001, 8'hC0, 1, 0);
    add(1, 4'b0000, 32'hC3C2C1C0,  0, 4'b0001, 0, 4'b0000, 8'hC0, 1, 0);
    add(1, 4'b0000, 32'hC3C2C1C0,  0, 4'b0000, 0, 4'b0000, 8'h00, 0, 0);
    // full back-pressure on owner 2 after two words, then rotation to 3
    add(0, 4'b0000, 32'h0,         0, 4'b0000, 0, 4'b0000, 8'h00, 0, 0);
    add(1, 4'b0100, 32'h00D00000,  0, 4'b0000, 0, 4'b0000, 8'h00, 0, 0);
    add(1, 4'b0100, 32'h00D00000,  0, 4'b0100, 1, 4'b0100, 8'hD0, 1, 2);
    add(1, 4'b0100, 32'h00D00000,  0, 4'b0100, 1, 4'b0100, 8'hD0, 1, 2);
    for (int k = 0; k < 5; k++)
      add(1, 4'b0100, 32'h00D00000, 1, 4'b0100, 0, 4'b0000, 8'hD0, 1, 2);
    add(1, 4'b0100, 32'h00D00000,  0, 4'b0100, 1, 4'b0100, 8'hD0, 1, 2);
    add(1, 4'b1100, 32'hE0D00000,  0, 4'b0100, 1, 4'b0100, 8'hD0, 1, 2);
    add(1, 4'b1100, 32'hE0D00000,  0, 4'b1000, 1, 4'b1000, 8'hE0, 1, 3);
    // asynchronous reset mid-burst, then first grant goes to producer 0
    add(0, 4'b1100, 32'hE0D00000,  0, 4'b0000, 0, 4'b0000, 8'h00, 0, 0);
    add(1, 4'b1111, 32'hC3C2C1C0,  0, 4'b0000, 0, 4'b0000, 8'h00, 0, 0);
    add(1, 4'b1111, 32'hC3C2C1C0,  0, 4'b0001, 1, 4'b0001, 8'hC0, 1, 0);

    #2;
    for (int k = 0; k < tbl.size(); k++) begin
      @(posedge clock); #1;
      reset     = tbl[k].rst_n;
      req       = tbl[k].req;
      req_data  = tbl[k].data;
      fifo_full = tbl[k].full;
      @(negedge clock);
      chk($sformatf("v%0d_gnt", k),   32'(gnt),             32'(tbl[k].e_gnt));
      chk($sformatf("v%0d_wen", k),   32'(fifo_w_enable),   32'(tbl[k].e_wen));
      chk($sformatf("v%0d_acc", k),   32'(accept),          32'(tbl[k].e_acc));
      chk($sformatf("v%0d_wdata", k), 32'(fifo_write_data), 32'(tbl[k].e_wd));
      chk($sformatf("v%0d_busy", k),  32'(busy),            32'(tbl[k].e_busy));
      chk($sformatf("v%0d_owner", k), 32'(owner),           32'(tbl[k].e_owner));
    end

    // integration with a depth-16 FIFO model: 4 producers x 4 words
    @(posedge clock); #1;
    reset = 1'b0; req = '0; req_data = '0; fifo_full = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) j[i] = 0;
    for (int i = 0; i < 4; i++) begin
      req[i] = (j[i] < 4);
      req_data[i*8 +: 8] = 8'(160 + i*4 + j[i]);
    end
    writes = 0;
    cyc    = 0;
    while (writes < 16 && cyc < 200) begin
      @(negedge clock);
      if (fifo_w_enable) begin
        chk("intg_no_write_while_full", 32'(fifo_full), 32'd0);
        q.push_back(fifo_write_data);
        writes++;
        for (int i = 0; i < 4; i++) if (accept[i]) j[i]++;
      end
      @(posedge clock); #1;
      fifo_full = (q.size() >= 16);
      for (int i = 0; i < 4; i++) begin
        req[i] = (j[i] < 4);
        req_data[i*8 +: 8] = 8'(160 + i*4 + j[i]);
      end
      cyc++;
    end
    chk("intg_writes", 32'(writes), 32'd16);
    chk("intg_cycles", 32'(cyc), 32'd17);

    // an extra request while the FIFO is full must stall under its grant
    req = 4'b0001; req_data = 32'h000000FF;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      chk($sformatf("full_stall%0d_wen", k), 32'(fifo_w_enable), 32'd0);
      @(posedge clock); #1;
    end
    @(negedge clock);
    chk("full_stall_gnt", 32'(gnt), 32'b0001);
    @(posedge clock); #1;
    req = '0;

    for (int k = 0; k < 16; k++) begin
      if (q.size() > 0) chk($sformatf("intg_read%0d", k), 32'(q.pop_front()), 32'(160 + k));
      else chk($sformatf("intg_read%0d_missing", k), 32'd0, 32'd1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
